// File: rtl/mig_app_if.sv
// Bundle of the app_* command, write-data and read-data signals between a
// DDR-style app port master (e.g. the VDMA) and the responder.
interface mig_app_if #(
  parameter int ASIZE     = 29,
  parameter int AXI_DSIZE = 256
);
  // Handshakes: a command transfers on a cycle with app_en && app_rdy, a
  // write beat on app_wdf_wren && app_wdf_rdy; the master holds its payload
  // stable while valid is high and ready is low. Read data has no ready and
  // is consumed on every cycle app_rd_data_valid is high.
  logic [ASIZE-1:0]       app_addr;
  logic [2:0]             app_cmd;
  logic                   app_en;
  logic                   app_rdy;
  logic [AXI_DSIZE-1:0]   app_wdf_data;
  logic [AXI_DSIZE/8-1:0] app_wdf_mask;
  logic                   app_wdf_wren;
  logic                   app_wdf_end;
  logic                   app_wdf_rdy;
  logic [AXI_DSIZE-1:0]   app_rd_data;
  logic                   app_rd_data_valid;
  logic                   app_rd_data_end;

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_app_responder.sv
// On-chip RAM responder for the app_* protocol: command and write-data FIFOs,
// strictly in-order executor, fixed-latency read pipeline, fake calibration.
module mig_app_responder #(
  parameter int ASIZE        = 29,
  parameter int AXI_DSIZE    = 256,
  parameter int MEM_AWIDTH   = 10,
  parameter int ADDR_SHIFT   = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic     axi_aclk,
  input  logic     axi_reset,
  mig_app_if.slave app,
  output logic     init_calib_complete,
  output logic     cmd_err
);
  localparam int MW   = AXI_DSIZE / 8;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic                  is_read;
    logic [MEM_AWIDTH-1:0] idx;
  } cmd_t;

  typedef struct packed {
    logic [AXI_DSIZE-1:0] data;
    logic [MW-1:0]        mask;
  } wdf_t;

  logic [CW-1:0]   calib_cnt_q, calib_cnt_d;
  logic            calib_q, calib_d;
  logic            cmd_err_q, cmd_err_d;
  cmd_t            cmd_fifo_q [FIFO_DEPTH];
  cmd_t            cmd_fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CNTW-1:0] cmd_cnt_q, cmd_cnt_d;
  wdf_t            wdf_fifo_q [FIFO_DEPTH];
  wdf_t            wdf_fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wdf_wr_q, wdf_wr_d, wdf_rd_q, wdf_rd_d;
  logic [CNTW-1:0] wdf_cnt_q, wdf_cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [AXI_DSIZE-1:0]  rd_data_q [1:RD_LATENCY-1];
  logic [AXI_DSIZE-1:0]  rd_data_d [1:RD_LATENCY-1];
  logic [AXI_DSIZE-1:0]  ram_q;
  logic [AXI_DSIZE-1:0]  mem [2**MEM_AWIDTH];

  logic app_rdy, wdf_rdy, cmd_acc, cmd_legal, cmd_push, wdf_push;
  logic exec_wr, exec_rd;
  cmd_t cmd_head;
  wdf_t wdf_head;
  logic addr_unused;

  // Upper address bits alias and the beat-offset bits are dropped.
  assign addr_unused = ^{app.app_addr[ASIZE-1:ADDR_SHIFT+MEM_AWIDTH],
                         app.app_addr[ADDR_SHIFT-1:0]};

  // Ready uses only registered counts, so a full FIFO never accepts even on a pop cycle.
  always_comb begin
    app_rdy   = calib_q && (cmd_cnt_q != CNTW'(FIFO_DEPTH));
    wdf_rdy   = calib_q && (wdf_cnt_q != CNTW'(FIFO_DEPTH));
    cmd_acc   = app.app_en && app_rdy;
    cmd_legal = (app.app_cmd == CMD_WRITE) || (app.app_cmd == CMD_READ);
    cmd_push  = cmd_acc && cmd_legal;
    wdf_push  = app.app_wdf_wren && wdf_rdy;
    cmd_head  = cmd_fifo_q[cmd_rd_q];
    wdf_head  = wdf_fifo_q[wdf_rd_q];
    exec_wr   = !axi_reset && (cmd_cnt_q != '0) && !cmd_head.is_read && (wdf_cnt_q != '0);
    exec_rd   = !axi_reset && (cmd_cnt_q != '0) && cmd_head.is_read;
  end

  always_comb begin
    calib_cnt_d = calib_q ? calib_cnt_q : calib_cnt_q + 1'b1;
    calib_d     = calib_q || (calib_cnt_q == CW'(CALIB_CYCLES - 1));
    cmd_err_d   = cmd_err_q || (cmd_acc && !cmd_legal) || (wdf_push && !app.app_wdf_end);

    cmd_fifo_d = cmd_fifo_q;
    if (cmd_push) begin
      cmd_fifo_d[cmd_wr_q].is_read = (app.app_cmd == CMD_READ);
      cmd_fifo_d[cmd_wr_q].idx     = app.app_addr[ADDR_SHIFT +: MEM_AWIDTH];
    end
    cmd_wr_d  = cmd_push ? cmd_wr_q + 1'b1 : cmd_wr_q;
    cmd_rd_d  = (exec_wr || exec_rd) ? cmd_rd_q + 1'b1 : cmd_rd_q;
    cmd_cnt_d = cmd_cnt_q + CNTW'(cmd_push) - CNTW'(exec_wr || exec_rd);

    wdf_fifo_d = wdf_fifo_q;
    if (wdf_push) begin
      wdf_fifo_d[wdf_wr_q].data = app.app_wdf_data;
      wdf_fifo_d[wdf_wr_q].mask = app.app_wdf_mask;
    end
    wdf_wr_d  = wdf_push ? wdf_wr_q + 1'b1 : wdf_wr_q;
    wdf_rd_d  = exec_wr ? wdf_rd_q + 1'b1 : wdf_rd_q;
    wdf_cnt_d = wdf_cnt_q + CNTW'(wdf_push) - CNTW'(exec_wr);

    // Stage 0 is the RAM output register; data is zeroed when no beat is in it.
    vld_d        = {vld_q[RD_LATENCY-2:0], exec_rd};
    rd_data_d[1] = vld_q[0] ? ram_q : '0;
    for (int i = 2; i < RD_LATENCY; i++) rd_data_d[i] = rd_data_q[i-1];
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      wdf_wr_q    <= '0;
      wdf_rd_q    <= '0;
      wdf_cnt_q   <= '0;
      vld_q       <= '0;
      rd_data_q   <= '{default: '0};
    end else begin
      calib_cnt_q <= calib_cnt_d;
      calib_q     <= calib_d;
      cmd_err_q   <= cmd_err_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_cnt_q   <= cmd_cnt_d;
      wdf_wr_q    <= wdf_wr_d;
      wdf_rd_q    <= wdf_rd_d;
      wdf_cnt_q   <= wdf_cnt_d;
      vld_q       <= vld_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    cmd_fifo_q <= cmd_fifo_d;
    wdf_fifo_q <= wdf_fifo_d;
  end

  // One command per cycle, so a write and a read never hit the RAM together;
  // a read issued the cycle after a write already sees the new word.
  always_ff @(posedge axi_aclk) begin
    if (exec_wr) begin
      for (int b = 0; b < MW; b++) begin
        if (!wdf_head.mask[b]) mem[cmd_head.idx][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
      end
    end
    if (exec_rd) ram_q <= mem[cmd_head.idx];
  end

  assign app.app_rdy           = app_rdy;
  assign app.app_wdf_rdy       = wdf_rdy;
  assign app.app_rd_data       = rd_data_q[RD_LATENCY-1];
  assign app.app_rd_data_valid = vld_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = vld_q[RD_LATENCY-1];
  assign init_calib_complete   = calib_q;
  assign cmd_err               = cmd_err_q;
endmodule
